// File: rtl/dac_frame_ctrl.sv
// Serial DAC frame sequencer: divides clk into SCLK, generates LRCK and the L/R load
// strobes, and buffers one stereo sample from upstream for the shifter.
module dac_frame_ctrl #(
   parameter int CLK_DIV  = 32,
   parameter int SLOT_LEN = 16,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   output logic              SCLK,
   output logic              LRCK,
   output logic              L_start,
   output logic              R_start,
   output logic [DATA_W-1:0] L_data,
   output logic [DATA_W-1:0] R_data,
   output logic              underrun,
   output logic [7:0]        underrun_cnt
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_LEN);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_LEN - 1);
   localparam logic [BIT_W-1:0] SLOT_B    = BIT_W'(SLOT_LEN);
   localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_LEN - 1);

   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [BIT_W-1:0]  bit_nxt;
   logic              pend_valid;
   logic [DATA_W-1:0] pend_left;
   logic [DATA_W-1:0] pend_right;
   logic              load_due;

   // Handshake: a sample transfers on any clk where in_valid && in_ready. in_ready is
   // purely a function of the registered pend_valid, so it never depends on in_valid.
   assign in_ready = !pend_valid;

   always_comb begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt      <= '0;
         bit_cnt      <= BIT_LAST;
         SCLK         <= 1'b0;
         LRCK         <= 1'b1;
         L_start      <= 1'b0;
         R_start      <= 1'b0;
         L_data       <= '0;
         R_data       <= '0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
         pend_valid   <= 1'b0;
         pend_left    <= '0;
         pend_right   <= '0;
         load_due     <= 1'b0;
      end else begin
         underrun <= 1'b0;
         load_due <= 1'b0;

         if (in_valid && !pend_valid) begin
            pend_left  <= in_left;
            pend_right <= in_right;
            pend_valid <= 1'b1;
         end

         // Frame load runs the clk after the rise event that raised L_start; an accept
         // cannot coincide with a consume because in_ready is low while pend_valid is set.
         if (load_due) begin
            if (pend_valid) begin
               L_data     <= pend_left;
               R_data     <= pend_right;
               pend_valid <= 1'b0;
            end else begin
               underrun <= 1'b1;
               if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
            end
         end

         if (!en) begin
            div_cnt <= '0;
            bit_cnt <= BIT_LAST;
            SCLK    <= 1'b0;
            LRCK    <= 1'b1;
            L_start <= 1'b0;
            R_start <= 1'b0;
         end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= !SCLK;
            if (!SCLK) begin
               // Strobes only move on rises, so each straddles exactly one falling edge.
               L_start  <= (bit_cnt == BIT_LAST);
               R_start  <= (bit_cnt == SLOT_LAST);
               load_due <= (bit_cnt == BIT_LAST);
            end else begin
               bit_cnt <= bit_nxt;
               LRCK    <= (bit_nxt >= SLOT_B);
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule
